// File: rtl/vie_mem_stage_sr.sv
// Memory stage of the VIE pipeline: holds one entry, merges the load response
// into the final result and drops responses that belong to flushed loads.
module vie_mem_stage_sr #(
    parameter int OP_W        = 8,
    parameter int DEST_W      = 7,
    parameter int MAX_DISCARD = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              rs_valid,
    input  logic              rs_res_from_mem,
    input  logic [OP_W-1:0]   rs_op,
    input  logic [1:0]        rs_sel,
    input  logic [DEST_W-1:0] rs_dest,
    input  logic [31:0]       rs_fixres,
    input  logic [31:0]       rs_pc,
    output logic              ms_allowin,
    input  logic              data_ok,
    input  logic [31:0]       data_rdata,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [DEST_W-1:0] ms_dest,
    output logic [31:0]       ms_pc,
    output logic [31:0]       ms_res,
    output logic              fwd_valid,
    output logic              fwd_pending
);

    localparam int CNT_W = (MAX_DISCARD > 0) ? $clog2(MAX_DISCARD + 1) : 1;

    localparam logic [OP_W-1:0] VIE_OP_LB  = OP_W'(0);
    localparam logic [OP_W-1:0] VIE_OP_LBU = OP_W'(1);
    localparam logic [OP_W-1:0] VIE_OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] VIE_OP_LHU = OP_W'(3);
    localparam logic [OP_W-1:0] VIE_OP_LW  = OP_W'(4);
    localparam logic [OP_W-1:0] VIE_OP_LWL = OP_W'(5);
    localparam logic [OP_W-1:0] VIE_OP_LWR = OP_W'(6);

    logic              ms_valid_q, ms_valid_d;
    logic              data_got_q, data_got_d;
    logic [CNT_W-1:0]  discard_cnt_q, discard_cnt_d;
    logic [31:0]       data_buf_q, data_buf_d;
    logic              res_from_mem_q, res_from_mem_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [1:0]        sel_q, sel_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [31:0]       fixres_q, fixres_d;
    logic [31:0]       pc_q, pc_d;

    logic        live_data;
    logic        drop_data;
    logic        ms_cango;
    logic        ms_leave;
    logic        capture;
    logic        buffer_data;
    logic        inc_held;
    logic        inc_in;
    int          cnt_sum;
    logic        cnt_overflow;
    logic [31:0] load_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_res;

    // Handshakes: an upstream entry transfers on a cycle where rs_valid && ms_allowin
    // and flush is low; an entry leaves on ms_to_ws_valid && ws_allowin. Neither
    // valid waits on its own ready, and a presented entry stays stable until taken.
    assign live_data = data_ok && (discard_cnt_q == '0);
    assign drop_data = data_ok && (discard_cnt_q != '0);

    assign ms_cango       = !res_from_mem_q || data_got_q || live_data;
    assign ms_allowin     = !ms_valid_q || (ms_cango && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_cango && !flush;
    assign ms_leave       = ms_to_ws_valid && ws_allowin;
    assign capture        = rs_valid && ms_allowin && !flush;

    assign buffer_data = live_data && ms_valid_q && res_from_mem_q && !data_got_q
                         && !ms_leave && !flush;

    // A killed load whose response is still in flight must be swallowed later.
    assign inc_held = flush && ms_valid_q && res_from_mem_q && !data_got_q && !live_data;
    assign inc_in   = flush && rs_valid && rs_res_from_mem;

    assign cnt_sum      = int'(discard_cnt_q) + int'(inc_held) + int'(inc_in) - int'(drop_data);
    assign cnt_overflow = cnt_sum > MAX_DISCARD;

    always_comb begin
        discard_cnt_d = CNT_W'(cnt_sum);
        if (cnt_overflow) begin
            discard_cnt_d = CNT_W'(MAX_DISCARD);
        end
    end

    always_comb begin
        ms_valid_d = ms_valid_q;
        data_got_d = data_got_q;
        if (flush) begin
            ms_valid_d = 1'b0;
            data_got_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = rs_valid;
            data_got_d = 1'b0;
        end else if (buffer_data) begin
            data_got_d = 1'b1;
        end
    end

    always_comb begin
        res_from_mem_d = res_from_mem_q;
        op_d           = op_q;
        sel_d          = sel_q;
        dest_d         = dest_q;
        fixres_d       = fixres_q;
        pc_d           = pc_q;
        data_buf_d     = data_buf_q;
        if (capture) begin
            res_from_mem_d = rs_res_from_mem;
            op_d           = rs_op;
            sel_d          = rs_sel;
            dest_d         = rs_dest;
            fixres_d       = rs_fixres;
            pc_d           = rs_pc;
        end
        if (buffer_data) begin
            data_buf_d = data_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ms_valid_q    <= 1'b0;
            data_got_q    <= 1'b0;
            discard_cnt_q <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            data_got_q    <= data_got_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Payload is qualified by ms_valid_q / data_got_q, so it carries no reset.
    always_ff @(posedge clock) begin
        res_from_mem_q <= res_from_mem_d;
        op_q           <= op_d;
        sel_q          <= sel_d;
        dest_q         <= dest_d;
        fixres_q       <= fixres_d;
        pc_q           <= pc_d;
        data_buf_q     <= data_buf_d;
    end

    assign load_word = data_got_q ? data_buf_q : data_rdata;

    always_comb begin
        case (sel_q)
            2'd0:    ld_byte = load_word[7:0];
            2'd1:    ld_byte = load_word[15:8];
            2'd2:    ld_byte = load_word[23:16];
            default: ld_byte = load_word[31:24];
        endcase
        ld_half = sel_q[1] ? load_word[31:16] : load_word[15:0];
    end

    // Misaligned halfwords (odd sel) produce zero rather than a split access.
    always_comb begin
        load_res = '0;
        case (op_q)
            VIE_OP_LB:  load_res = {{24{ld_byte[7]}}, ld_byte};
            VIE_OP_LBU: load_res = {24'b0, ld_byte};
            VIE_OP_LH:  load_res = sel_q[0] ? 32'b0 : {{16{ld_half[15]}}, ld_half};
            VIE_OP_LHU: load_res = sel_q[0] ? 32'b0 : {16'b0, ld_half};
            VIE_OP_LW:  load_res = load_word;
            VIE_OP_LWL: begin
                case (sel_q)
                    2'd0:    load_res = {load_word[7:0],  fixres_q[23:0]};
                    2'd1:    load_res = {load_word[15:0], fixres_q[15:0]};
                    2'd2:    load_res = {load_word[23:0], fixres_q[7:0]};
                    default: load_res = load_word;
                endcase
            end
            VIE_OP_LWR: begin
                case (sel_q)
                    2'd0:    load_res = load_word;
                    2'd1:    load_res = {fixres_q[31:24], load_word[31:8]};
                    2'd2:    load_res = {fixres_q[31:16], load_word[31:16]};
                    default: load_res = {fixres_q[31:8],  load_word[31:24]};
                endcase
            end
            default:    load_res = '0;
        endcase
    end

    assign ms_res      = res_from_mem_q ? load_res : fixres_q;
    assign ms_dest     = dest_q;
    assign ms_pc       = pc_q;
    assign fwd_valid   = ms_valid_q;
    assign fwd_pending = ms_valid_q && res_from_mem_q && !ms_cango;

`ifndef SYNTHESIS
    // More flushed loads in flight than the counter can track: responses would be misrouted.
    discard_ceiling_a: assert property (@(posedge clock) disable iff (!reset_n) !cnt_overflow);
`endif

endmodule

// File: tb/tb_vie_mem_stage_sr.sv
// Bench for vie_mem_stage_sr: directed scenarios plus random traffic, with an
// in-order memory model and a scoreboard queue checked by a decoupled monitor.
module tb_vie_mem_stage_sr;

    localparam int OP_W        = 8;
    localparam int DEST_W      = 7;
    localparam int MAX_DISCARD = 3;
    localparam int EXP_W       = DEST_W + 64;

    localparam logic [7:0] OP_LB  = 8'd0;
    localparam logic [7:0] OP_LBU = 8'd1;
    localparam logic [7:0] OP_LH  = 8'd2;
    localparam logic [7:0] OP_LHU = 8'd3;
    localparam logic [7:0] OP_LW  = 8'd4;
    localparam logic [7:0] OP_LWL = 8'd5;
    localparam logic [7:0] OP_LWR = 8'd6;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              rs_valid;
    logic              rs_res_from_mem;
    logic [OP_W-1:0]   rs_op;
    logic [1:0]        rs_sel;
    logic [DEST_W-1:0] rs_dest;
    logic [31:0]       rs_fixres;
    logic [31:0]       rs_pc;
    logic              ms_allowin;
    logic              data_ok;
    logic [31:0]       data_rdata;
    logic              ws_allowin;
    logic              ms_to_ws_valid;
    logic [DEST_W-1:0] ms_dest;
    logic [31:0]       ms_pc;
    logic [31:0]       ms_res;
    logic              fwd_valid;
    logic              fwd_pending;

    int total = 0;
    int bad   = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [31:0]      mem_q[$];
    bit               up_busy = 0;
    bit               up_load = 0;
    logic [31:0]      up_data = '0;
    logic [EXP_W-1:0] mon_e;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    vie_mem_stage_sr #(
        .OP_W(OP_W), .DEST_W(DEST_W), .MAX_DISCARD(MAX_DISCARD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .rs_valid(rs_valid), .rs_res_from_mem(rs_res_from_mem), .rs_op(rs_op),
        .rs_sel(rs_sel), .rs_dest(rs_dest), .rs_fixres(rs_fixres), .rs_pc(rs_pc),
        .ms_allowin(ms_allowin), .data_ok(data_ok), .data_rdata(data_rdata),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid), .ms_dest(ms_dest),
        .ms_pc(ms_pc), .ms_res(ms_res), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference load semantics written as plain byte arithmetic.
    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [1:0] sel,
                                             input logic [31:0] fix, input logic [31:0] mem);
        longint m, f, b, h, r;
        int s, sh;
        m = longint'(mem);
        f = longint'(fix);
        s = int'(sel);
        r = 0;
        b = (m >> (8 * s)) & 64'hFF;
        h = (m >> (8 * s)) & 64'hFFFF;
        case (op)
            OP_LB:  r = (b >= 128) ? b - 256 : b;
            OP_LBU: r = b;
            OP_LH:  if (s % 2 == 0) r = (h >= 32768) ? h - 65536 : h;
            OP_LHU: if (s % 2 == 0) r = h;
            OP_LW:  r = m;
            OP_LWL: begin
                sh = 8 * (3 - s);
                r = (m << sh) | (f & ((64'd1 << sh) - 1));
            end
            OP_LWR: begin
                sh = 8 * s;
                r = (m >> sh) | (f & ~(64'hFFFF_FFFF >> sh));
            end
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic present(input logic [7:0] op, input logic [1:0] sel, input logic [DEST_W-1:0] dest,
                           input logic [31:0] fix, input logic [31:0] pc, input bit ld,
                           input logic [31:0] data);
        rs_valid        = 1'b1;
        rs_res_from_mem = ld;
        rs_op           = op;
        rs_sel          = sel;
        rs_dest         = dest;
        rs_fixres       = fix;
        rs_pc           = pc;
        up_busy         = 1;
        up_load         = ld;
        up_data         = data;
        if (ld) mem_q.push_back(data);
    endtask

    // Memory only answers a load once it has left the upstream stage.
    task automatic drive(input bit fl, input bit dok, input bit ws);
        bit can;
        can        = mem_q.size() > ((up_busy && up_load) ? 1 : 0);
        flush      = fl;
        ws_allowin = ws;
        if (dok && can) begin
            data_ok    = 1'b1;
            data_rdata = mem_q[0];
        end else begin
            data_ok    = 1'b0;
            data_rdata = $urandom;
        end
    endtask

    task automatic finish_cycle();
        logic [31:0] tmp;
        @(negedge clock);
        if (rs_valid && ms_allowin && !flush) begin
            exp_q.push_back({rs_dest, rs_pc,
                             up_load ? ref_load(rs_op, rs_sel, rs_fixres, up_data) : rs_fixres});
            up_busy = 0;
        end
        if (data_ok) tmp = mem_q.pop_front();
        if (flush) begin
            exp_q.delete();
            up_busy = 0;
        end
        @(posedge clock);
        #1;
        if (!up_busy) rs_valid = 1'b0;
    endtask

    task automatic tick(input bit fl, input bit dok, input bit ws);
        drive(fl, dok, ws);
        finish_cycle();
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset_n === 1'b1 && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got pc %h want no entry", ms_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_dest", 32'(ms_dest), 32'(mon_e[EXP_W-1 -: DEST_W]));
                chk("out_pc", ms_pc, mon_e[63:32]);
                chk("out_res", ms_res, mon_e[31:0]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; flush = 1'b0; rs_valid = 1'b0; rs_res_from_mem = 1'b0;
        rs_op = '0; rs_sel = '0; rs_dest = '0; rs_fixres = '0; rs_pc = '0;
        data_ok = 1'b0; data_rdata = '0; ws_allowin = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_fwd_pending", 32'(fwd_pending), 32'd0);
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // ALU entry passes fixres through
        present(OP_LW, 2'd0, 7'd5, 32'h1234_5678, 32'h0000_0100, 0, 32'h0);
        tick(0, 0, 1);
        drive(0, 0, 1);
        #1;
        chk("alu_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("alu_res", ms_res, 32'h1234_5678);
        chk("alu_allowin", 32'(ms_allowin), 32'd1);
        finish_cycle();

        // LB sel 3 with the response in the first held cycle
        present(OP_LB, 2'd3, 7'd6, 32'h0, 32'h0000_0104, 1, 32'h80AA_BBCC);
        tick(0, 0, 1);
        drive(0, 1, 1);
        #1;
        chk("lb_zero_lat_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("lb_zero_lat_res", ms_res, 32'hFFFF_FF80);
        finish_cycle();

        // LW buffered while writeback stalls
        present(OP_LW, 2'd0, 7'd7, 32'h0, 32'h0000_0108, 1, 32'hDEAD_BEEF);
        tick(0, 0, 0);
        drive(0, 0, 0);
        #1;
        chk("lw_wait_pending", 32'(fwd_pending), 32'd1);
        chk("lw_wait_allowin", 32'(ms_allowin), 32'd0);
        finish_cycle();
        drive(0, 1, 0);
        #1;
        chk("lw_data_allowin", 32'(ms_allowin), 32'd0);
        finish_cycle();
        repeat (2) begin
            drive(0, 0, 0);
            #1;
            chk("lw_buf_pending", 32'(fwd_pending), 32'd0);
            chk("lw_buf_allowin", 32'(ms_allowin), 32'd0);
            finish_cycle();
        end
        drive(0, 0, 1);
        #1;
        chk("lw_buf_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("lw_buf_res", ms_res, 32'hDEAD_BEEF);
        finish_cycle();

        // LWL / LWR merge
        present(OP_LWL, 2'd1, 7'd8, 32'h1122_3344, 32'h0000_010C, 1, 32'hAABB_CCDD);
        tick(0, 0, 1);
        drive(0, 1, 1);
        #1;
        chk("lwl_res", ms_res, 32'hCCDD_3344);
        finish_cycle();
        present(OP_LWR, 2'd1, 7'd9, 32'h1122_3344, 32'h0000_0110, 1, 32'hAABB_CCDD);
        tick(0, 0, 1);
        drive(0, 1, 1);
        #1;
        chk("lwr_res", ms_res, 32'h11AA_BBCC);
        finish_cycle();

        // Flush with a held pending load and an incoming load: two responses dropped
        present(OP_LW, 2'd0, 7'd10, 32'h0, 32'h0000_0200, 1, 32'hA000_0001);
        tick(0, 0, 1);
        present(OP_LW, 2'd0, 7'd11, 32'h0, 32'h0000_0204, 1, 32'hB000_0002);
        drive(1, 0, 1);
        #1;
        chk("flush_valid", 32'(ms_to_ws_valid), 32'd0);
        finish_cycle();
        present(OP_LW, 2'd0, 7'd12, 32'h0, 32'h0000_0208, 1, 32'hC0FF_EE00);
        tick(0, 0, 1);
        repeat (2) begin
            drive(0, 1, 1);
            #1;
            chk("discard_valid", 32'(ms_to_ws_valid), 32'd0);
            chk("discard_pending", 32'(fwd_pending), 32'd1);
            finish_cycle();
        end
        drive(0, 1, 1);
        #1;
        chk("after_discard_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("after_discard_res", ms_res, 32'hC0FF_EE00);
        finish_cycle();

        // Asynchronous reset while a load is pending and discards are outstanding
        present(OP_LW, 2'd0, 7'd13, 32'h0, 32'h0000_0300, 1, 32'h1111_0001);
        tick(0, 0, 1);
        present(OP_LW, 2'd0, 7'd14, 32'h0, 32'h0000_0304, 1, 32'h2222_0002);
        tick(1, 0, 1);
        present(OP_LW, 2'd0, 7'd15, 32'h0, 32'h0000_0308, 1, 32'h3333_0003);
        tick(0, 0, 1);
        drive(0, 0, 1);
        #1;
        chk("prereset_pending", 32'(fwd_pending), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("async_rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("async_rst_fwd_pending", 32'(fwd_pending), 32'd0);
        chk("async_rst_allowin", 32'(ms_allowin), 32'd1);
        exp_q.delete();
        mem_q.delete();
        up_busy = 0;
        rs_valid = 1'b0;
        data_ok = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        present(OP_LW, 2'd0, 7'd16, 32'h0, 32'h0000_030C, 1, 32'h4444_0004);
        tick(0, 0, 1);
        drive(0, 1, 1);
        #1;
        chk("post_reset_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("post_reset_res", ms_res, 32'h4444_0004);
        finish_cycle();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit fl;
            if (!up_busy && $urandom_range(0, 3) != 0) begin
                present(8'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                        DEST_W'($urandom), $urandom, $urandom,
                        $urandom_range(0, 2) != 0, $urandom);
            end
            fl = ($urandom_range(0, 11) == 0) && (mem_q.size() <= 2);
            tick(fl, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end

        for (int g = 0; g < 400; g++) begin
            if (exp_q.size() == 0 && mem_q.size() == 0 && !up_busy) break;
            tick(0, 1, 1);
        end
        chk("drain_left", 32'(exp_q.size() + mem_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
